// File: rtl/queue_ptr_manager.sv
// queue_ptr_manager: tracks tail / commit_head / inflight_head per queue and
// hands out dequeue operations through an in-order circular op table.
// Optional feature macro: QPM_STATS_EN adds three saturating 32-bit response
// counters (stat_dequeue_count, stat_empty_count, stat_error_count).
//
// Handshake: request, response and commit channels transfer on a rising clk
// edge where valid && ready are both high. A source holding valid keeps its
// payload stable until that edge. The doorbell channel has no ready and is
// always taken. commit_ready is permanently high.
module queue_ptr_manager #(
  parameter int QUEUE_COUNT   = 8,
  parameter int PTR_WIDTH     = 16,
  parameter int TAG_WIDTH     = 8,
  parameter int OP_TABLE_SIZE = 4,
  localparam int QIW = $clog2(QUEUE_COUNT),
  localparam int OTW = $clog2(OP_TABLE_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic [QIW-1:0]       s_axis_dequeue_req_queue,
  input  logic [TAG_WIDTH-1:0] s_axis_dequeue_req_tag,
  input  logic                 s_axis_dequeue_req_valid,
  output logic                 s_axis_dequeue_req_ready,

  output logic [QIW-1:0]       m_axis_dequeue_resp_queue,
  output logic [PTR_WIDTH-1:0] m_axis_dequeue_resp_ptr,
  output logic [TAG_WIDTH-1:0] m_axis_dequeue_resp_tag,
  output logic [OTW-1:0]       m_axis_dequeue_resp_op_tag,
  output logic                 m_axis_dequeue_resp_empty,
  output logic                 m_axis_dequeue_resp_error,
  output logic                 m_axis_dequeue_resp_valid,
  input  logic                 m_axis_dequeue_resp_ready,

  input  logic [OTW-1:0]       s_axis_dequeue_commit_op_tag,
  input  logic                 s_axis_dequeue_commit_valid,
  output logic                 s_axis_dequeue_commit_ready,

  input  logic [QIW-1:0]       s_axis_doorbell_queue,
  input  logic [PTR_WIDTH-1:0] s_axis_doorbell_ptr,
  input  logic                 s_axis_doorbell_valid,

  input  logic                 cfg_wr_en,
  input  logic [QIW-1:0]       cfg_queue,
  input  logic [3:0]           cfg_log_size,
  input  logic                 cfg_active,

  input  logic                 enable
`ifdef QPM_STATS_EN
  ,
  output logic [31:0]          stat_dequeue_count,
  output logic [31:0]          stat_empty_count,
  output logic [31:0]          stat_error_count
`endif
);

  // The doorbell window 2^log_size can reach 2^15, so the comparison needs at
  // least 17 bits even when pointers are narrow.
  localparam int LW = (PTR_WIDTH > 16) ? PTR_WIDTH + 1 : 17;
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);
  localparam logic [OTW:0]         OP_ONE  = (OTW + 1)'(1);
  localparam logic [LW-1:0]        LIM_ONE = LW'(1);

  // Per-queue state
  logic [PTR_WIDTH-1:0] tail_q          [QUEUE_COUNT];
  logic [PTR_WIDTH-1:0] commit_head_q   [QUEUE_COUNT];
  logic [PTR_WIDTH-1:0] inflight_head_q [QUEUE_COUNT];
  logic [3:0]           log_size_q      [QUEUE_COUNT];
  logic                 active_q        [QUEUE_COUNT];

  // Op table: each slot remembers which queue the operation belongs to.
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [QIW-1:0]       op_queue_q [OP_TABLE_SIZE];
  logic [OTW:0]         op_wr_q;
  logic [OTW:0]         op_rd_q;
  logic [OTW-1:0]       op_wr_idx;
  logic [OTW-1:0]       op_rd_idx;
  logic                 op_empty;
  logic                 op_full;

  // Request decode
  logic                 req_fire;
  logic                 req_error;
  logic                 req_empty;
  logic                 req_alloc;

  // Commit decode
  logic                 commit_fire;
  logic [QIW-1:0]       commit_queue;

  // Doorbell decode
  logic [PTR_WIDTH-1:0] db_diff;
  logic [LW-1:0]        db_limit;
  logic                 db_accept;

  // Op table occupancy derived from the read/write pointers
  always_comb begin
    op_wr_idx = op_wr_q[OTW-1:0];
    op_rd_idx = op_rd_q[OTW-1:0];
    op_empty  = (op_wr_q == op_rd_q);
    op_full   = (op_wr_q[OTW] != op_rd_q[OTW]) && (op_wr_idx == op_rd_idx);
  end

  // Request acceptance and classification (error / empty / allocate).
  // op_full is registered, so a commit freeing a slot only raises ready next cycle.
  always_comb begin
    s_axis_dequeue_req_ready = rst_n
                               && (!m_axis_dequeue_resp_valid || m_axis_dequeue_resp_ready)
                               && !op_full;
    req_fire  = s_axis_dequeue_req_valid && s_axis_dequeue_req_ready;
    req_error = !active_q[s_axis_dequeue_req_queue] || !enable;
    req_empty = !req_error
                && (inflight_head_q[s_axis_dequeue_req_queue] == tail_q[s_axis_dequeue_req_queue]);
    req_alloc = req_fire && !req_error && !req_empty;
  end

  // Commits retire only the oldest live op; anything else is dropped
  always_comb begin
    s_axis_dequeue_commit_ready = 1'b1;
    commit_queue = op_queue_q[op_rd_idx];
    commit_fire  = s_axis_dequeue_commit_valid && !op_empty
                   && (s_axis_dequeue_commit_op_tag == op_rd_idx);
  end

  // Doorbell is taken only if the new tail stays within one ring of commit_head
  always_comb begin
    db_diff   = s_axis_doorbell_ptr - commit_head_q[s_axis_doorbell_queue];
    db_limit  = LIM_ONE << log_size_q[s_axis_doorbell_queue];
    db_accept = s_axis_doorbell_valid && (LW'(db_diff) <= db_limit);
  end

  // Per-queue pointer and configuration updates; cfg writes win over everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_COUNT; i++) begin
        tail_q[i]          <= '0;
        commit_head_q[i]   <= '0;
        inflight_head_q[i] <= '0;
        log_size_q[i]      <= '0;
        active_q[i]        <= 1'b0;
      end
    end else begin
      for (int i = 0; i < QUEUE_COUNT; i++) begin
        if (db_accept && (s_axis_doorbell_queue == QIW'(i))) begin
          tail_q[i] <= s_axis_doorbell_ptr;
        end
        if (req_alloc && (s_axis_dequeue_req_queue == QIW'(i))) begin
          inflight_head_q[i] <= inflight_head_q[i] + PTR_ONE;
        end
        if (commit_fire && (commit_queue == QIW'(i))) begin
          commit_head_q[i] <= commit_head_q[i] + PTR_ONE;
        end
        if (cfg_wr_en && (cfg_queue == QIW'(i))) begin
          log_size_q[i]      <= cfg_log_size;
          active_q[i]        <= cfg_active;
          tail_q[i]          <= '0;
          commit_head_q[i]   <= '0;
          inflight_head_q[i] <= '0;
        end
      end
    end
  end

  // Op table allocation on successful dequeue, retirement on matching commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_wr_q <= '0;
      op_rd_q <= '0;
      for (int i = 0; i < OP_TABLE_SIZE; i++) begin
        op_queue_q[i] <= '0;
      end
    end else begin
      if (req_alloc) begin
        op_queue_q[op_wr_idx] <= s_axis_dequeue_req_queue;
        op_wr_q               <= op_wr_q + OP_ONE;
      end
      if (commit_fire) begin
        op_rd_q <= op_rd_q + OP_ONE;
      end
    end
  end

  // Registered response: loaded on acceptance, held until the consumer takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_axis_dequeue_resp_valid  <= 1'b0;
      m_axis_dequeue_resp_queue  <= '0;
      m_axis_dequeue_resp_ptr    <= '0;
      m_axis_dequeue_resp_tag    <= '0;
      m_axis_dequeue_resp_op_tag <= '0;
      m_axis_dequeue_resp_empty  <= 1'b0;
      m_axis_dequeue_resp_error  <= 1'b0;
    end else if (req_fire) begin
      m_axis_dequeue_resp_valid  <= 1'b1;
      m_axis_dequeue_resp_queue  <= s_axis_dequeue_req_queue;
      m_axis_dequeue_resp_tag    <= s_axis_dequeue_req_tag;
      m_axis_dequeue_resp_error  <= req_error;
      m_axis_dequeue_resp_empty  <= req_empty;
      m_axis_dequeue_resp_ptr    <= req_alloc ? inflight_head_q[s_axis_dequeue_req_queue] : '0;
      m_axis_dequeue_resp_op_tag <= req_alloc ? op_wr_idx : '0;
    end else if (m_axis_dequeue_resp_ready) begin
      m_axis_dequeue_resp_valid  <= 1'b0;
    end
  end

`ifdef QPM_STATS_EN
  logic resp_fire;
  assign resp_fire = m_axis_dequeue_resp_valid && m_axis_dequeue_resp_ready;

  // Saturating counters of consumed responses, split by response type
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_dequeue_count <= '0;
      stat_empty_count   <= '0;
      stat_error_count   <= '0;
    end else if (resp_fire) begin
      if (m_axis_dequeue_resp_error) begin
        if (stat_error_count != '1) stat_error_count <= stat_error_count + 32'd1;
      end else if (m_axis_dequeue_resp_empty) begin
        if (stat_empty_count != '1) stat_empty_count <= stat_empty_count + 32'd1;
      end else begin
        if (stat_dequeue_count != '1) stat_dequeue_count <= stat_dequeue_count + 32'd1;
      end
    end
  end
`else
  // Statistics are not built: no counters and no stat ports.
`endif

endmodule

// File: tb/tb_queue_ptr_manager.sv
// tb_queue_ptr_manager: scoreboard bench for queue_ptr_manager.
// Pointers are 8 bits wide here so the ring wrap (0xFE -> 0xFF -> 0x00) is
// reachable in a few hundred operations.
`timescale 1ns/1ps
module tb_queue_ptr_manager;
  localparam int QC  = 8;
  localparam int PW  = 8;
  localparam int TW  = 8;
  localparam int OTS = 4;
  localparam int QIW = 3;
  localparam int OTW = 2;
  localparam int RW  = QIW + PW + TW + OTW + 2;
  localparam int K_DEQ   = 0;
  localparam int K_EMPTY = 1;
  localparam int K_ERR   = 2;
  localparam logic [PW-1:0]  ZP = '0;
  localparam logic [OTW-1:0] ZO = '0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [QIW-1:0] req_queue;
  logic [TW-1:0]  req_tag;
  logic           req_valid;
  logic           req_ready;
  logic [QIW-1:0] m_queue;
  logic [PW-1:0]  m_ptr;
  logic [TW-1:0]  m_tag;
  logic [OTW-1:0] m_op_tag;
  logic           m_empty;
  logic           m_error;
  logic           m_valid;
  logic           m_ready;
  logic [OTW-1:0] commit_op_tag;
  logic           commit_valid;
  logic           commit_ready;
  logic [QIW-1:0] db_queue;
  logic [PW-1:0]  db_ptr;
  logic           db_valid;
  logic           cfg_wr_en;
  logic [QIW-1:0] cfg_queue;
  logic [3:0]     cfg_log_size;
  logic           cfg_active;
  logic           enable;
`ifdef QPM_STATS_EN
  logic [31:0]    stat_dequeue_count;
  logic [31:0]    stat_empty_count;
  logic [31:0]    stat_error_count;
`endif

  queue_ptr_manager #(
    .QUEUE_COUNT(QC), .PTR_WIDTH(PW), .TAG_WIDTH(TW), .OP_TABLE_SIZE(OTS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_dequeue_req_queue(req_queue),
    .s_axis_dequeue_req_tag(req_tag),
    .s_axis_dequeue_req_valid(req_valid),
    .s_axis_dequeue_req_ready(req_ready),
    .m_axis_dequeue_resp_queue(m_queue),
    .m_axis_dequeue_resp_ptr(m_ptr),
    .m_axis_dequeue_resp_tag(m_tag),
    .m_axis_dequeue_resp_op_tag(m_op_tag),
    .m_axis_dequeue_resp_empty(m_empty),
    .m_axis_dequeue_resp_error(m_error),
    .m_axis_dequeue_resp_valid(m_valid),
    .m_axis_dequeue_resp_ready(m_ready),
    .s_axis_dequeue_commit_op_tag(commit_op_tag),
    .s_axis_dequeue_commit_valid(commit_valid),
    .s_axis_dequeue_commit_ready(commit_ready),
    .s_axis_doorbell_queue(db_queue),
    .s_axis_doorbell_ptr(db_ptr),
    .s_axis_doorbell_valid(db_valid),
    .cfg_wr_en(cfg_wr_en),
    .cfg_queue(cfg_queue),
    .cfg_log_size(cfg_log_size),
    .cfg_active(cfg_active),
    .enable(enable)
`ifdef QPM_STATS_EN
    ,
    .stat_dequeue_count(stat_dequeue_count),
    .stat_empty_count(stat_empty_count),
    .stat_error_count(stat_error_count)
`endif
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk(input logic [QIW-1:0] q, input logic [PW-1:0] p,
                                       input logic [TW-1:0] t, input logic [OTW-1:0] o,
                                       input logic e, input logic er);
    return {q, p, t, o, e, er};
  endfunction

  // ptr/op_tag carry no meaning on empty or error responses, so they are masked
  function automatic logic [RW-1:0] observed(input logic masked);
    return {m_queue, masked ? ZP : m_ptr, m_tag, masked ? ZO : m_op_tag, m_empty, m_error};
  endfunction

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        check("resp", 64'(observed(e[1] | e[0])), 64'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  int op_next = 0;
  int tg;
  int tg2;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int q, input int ls, input logic act);
    cfg_wr_en = 1'b1; cfg_queue = QIW'(q); cfg_log_size = 4'(ls); cfg_active = act;
    step();
    cfg_wr_en = 1'b0;
  endtask

  task automatic do_doorbell(input int q, input int p);
    db_valid = 1'b1; db_queue = QIW'(q); db_ptr = PW'(p);
    step();
    db_valid = 1'b0;
  endtask

  task automatic do_commit(input int t);
    commit_valid = 1'b1; commit_op_tag = OTW'(t);
    step();
    commit_valid = 1'b0;
  endtask

  task automatic do_request(input int q, input int tag, input int kind, input int ptr);
    logic [RW-1:0] e;
    logic ok;
    e = mk(QIW'(q), (kind == K_DEQ) ? PW'(ptr) : ZP, TW'(tag),
           (kind == K_DEQ) ? OTW'(op_next) : ZO, kind == K_EMPTY, kind == K_ERR);
    req_queue = QIW'(q); req_tag = TW'(tag); req_valid = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < 40; w++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      check("req_ready_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    if (kind == K_DEQ) op_next++;
    step();
    req_valid = 1'b0;
    check("resp_latency", 64'(m_valid), 64'd1);
  endtask

  task automatic check_reset(input string name);
    check({name, "_resp_valid"}, 64'(m_valid), 64'd0);
    check({name, "_req_ready"}, 64'(req_ready), 64'd0);
    check({name, "_resp_fields"}, 64'({m_queue, m_ptr, m_tag, m_op_tag, m_empty, m_error}), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    req_queue = '0; req_tag = '0; req_valid = 1'b0; m_ready = 1'b1;
    commit_op_tag = '0; commit_valid = 1'b0;
    db_queue = '0; db_ptr = '0; db_valid = 1'b0;
    cfg_wr_en = 1'b0; cfg_queue = '0; cfg_log_size = '0; cfg_active = 1'b0;
    enable = 1'b1;

    step();
    step();
    check_reset("reset");
    rst_n = 1'b1;
    step();

    // Basic dequeue, then empty once inflight_head reaches tail
    do_cfg(3, 4, 1'b1);
    do_doorbell(3, 2);
    do_request(3, 'h11, K_DEQ, 0);
    do_request(3, 'h12, K_DEQ, 1);
    do_request(3, 'h13, K_EMPTY, 0);
    do_commit(0);
    do_commit(1);

    // Fill the op table; stray commit dropped; in-order commit frees a slot
    do_cfg(4, 2, 1'b1);
    do_doorbell(4, 4);
    for (int i = 0; i < 4; i++) do_request(4, 'h20 + i, K_DEQ, i);
    @(negedge clk);
    check("full_req_ready", 64'(req_ready), 64'd0);
    step();
    commit_valid = 1'b1; commit_op_tag = 2'd3;
    @(negedge clk);
    check("stray_commit_cycle", 64'(req_ready), 64'd0);
    step();
    commit_valid = 1'b0;
    @(negedge clk);
    check("stray_commit_dropped", 64'(req_ready), 64'd0);
    step();
    commit_valid = 1'b1; commit_op_tag = 2'd2;
    @(negedge clk);
    check("freeing_commit_cycle", 64'(req_ready), 64'd0);
    step();
    commit_valid = 1'b0;
    @(negedge clk);
    check("freed_req_ready", 64'(req_ready), 64'd1);
    step();
    // ptr 5 fits the 4-entry window only if commit_head moved to 1
    do_doorbell(4, 5);
    do_request(4, 'h24, K_DEQ, 4);
    do_commit(3); do_commit(0); do_commit(1); do_commit(2);

    // Walk q5 up to commit_head 0xFE, then dequeue across the wrap
    do_cfg(5, 4, 1'b1);
    for (int i = 0; i < 254; i++) begin
      do_doorbell(5, i + 1);
      tg = op_next;
      do_request(5, i, K_DEQ, i);
      do_commit(tg);
    end
    do_doorbell(5, 3);
    tg = op_next;
    do_request(5, 'hA0, K_DEQ, 'hFE);
    do_request(5, 'hA1, K_DEQ, 'hFF);
    do_request(5, 'hA2, K_DEQ, 'h00);
    do_commit(tg); do_commit(tg + 1); do_commit(tg + 2);

    // Doorbell window boundary: 17 rejected, 16 accepted
    do_cfg(6, 4, 1'b1);
    do_doorbell(6, 17);
    do_request(6, 'h60, K_EMPTY, 0);
    do_doorbell(6, 16);
    tg = op_next;
    do_request(6, 'h61, K_DEQ, 0);
    do_commit(tg);

    // cfg overrides a same-cycle doorbell on the same queue
    db_valid = 1'b1; db_queue = 3'd1; db_ptr = 8'd5;
    do_cfg(1, 4, 1'b1);
    db_valid = 1'b0;
    do_request(1, 'h10, K_EMPTY, 0);

    // enable low -> error; response holds while resp_ready low
    do_doorbell(1, 1);
    enable = 1'b0;
    m_ready = 1'b0;
    do_request(1, 'h5A, K_ERR, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", 64'(m_valid), 64'd1);
      check("hold_resp", 64'(observed(1'b1)), 64'(mk(3'd1, ZP, 8'h5A, ZO, 1'b0, 1'b1)));
      check("hold_req_ready", 64'(req_ready), 64'd0);
      step();
    end
    m_ready = 1'b1;
    enable = 1'b1;
    tg = op_next;
    do_request(1, 'h11, K_DEQ, 0);
    // Same-cycle doorbell: request still sees the old tail
    db_valid = 1'b1; db_queue = 3'd1; db_ptr = 8'd2;
    do_request(1, 'h12, K_EMPTY, 0);
    db_valid = 1'b0;
    tg2 = op_next;
    do_request(1, 'h13, K_DEQ, 1);
    do_request(7, 'h70, K_ERR, 0);
    do_commit(tg);
    do_commit(tg2);

    // Reset with two ops in flight and a response pending
    do_cfg(2, 2, 1'b1);
    do_doorbell(2, 3);
    do_request(2, 'h30, K_DEQ, 0);
    do_request(2, 'h31, K_DEQ, 1);
    m_ready = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    step();
    check_reset("midop_reset");
    rst_n = 1'b1;
    m_ready = 1'b1;
    op_next = 0;
    step();

    do_request(3, 'h40, K_ERR, 0);
    do_cfg(2, 2, 1'b1);
    do_doorbell(2, 3);
    do_commit(0);
    // Rejected unless the stale commit wrongly bumped commit_head
    do_doorbell(2, 5);
    do_request(2, 'h41, K_DEQ, 0);
    do_request(2, 'h42, K_DEQ, 1);
    do_request(2, 'h43, K_DEQ, 2);
    do_request(2, 'h44, K_EMPTY, 0);
    do_commit(0); do_commit(1); do_commit(2);

    step(); step(); step();
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/queue_ptr_manager.md
QUEUE_PTR_MANAGER -- requirements
Module: queue_ptr_manager

Interface
REQ-001 SHALL have parameter QUEUE_COUNT, default 8, number of queues (power of 2, 2..256).
REQ-002 SHALL have parameter PTR_WIDTH, default 16, queue pointer width.
REQ-003 SHALL have parameter TAG_WIDTH, default 8, request tag width.
REQ-004 SHALL have parameter OP_TABLE_SIZE, default 4, max in-flight dequeue ops (power of 2); QIW = clog2(QUEUE_COUNT), OTW = clog2(OP_TABLE_SIZE).
REQ-005 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  reset, synchronous, active-low.
REQ-006 s_axis_dequeue_req_queue/_tag/_valid  in  QIW/TAG_WIDTH/1; s_axis_dequeue_req_ready  out  1.
REQ-007 m_axis_dequeue_resp_queue/_ptr/_tag/_op_tag/_empty/_error/_valid  out  QIW/PTR_WIDTH/TAG_WIDTH/OTW/1/1/1; m_axis_dequeue_resp_ready  in  1.
REQ-008 s_axis_dequeue_commit_op_tag/_valid  in  OTW/1; s_axis_dequeue_commit_ready  out  1.
REQ-009 s_axis_doorbell_queue/_ptr/_valid  in  QIW/PTR_WIDTH/1: producer tail update, no backpressure.
REQ-010 cfg_wr_en/cfg_queue/cfg_log_size/cfg_active  in  1/QIW/4/1: per-queue configuration write.
REQ-011 enable  in  1: global dequeue enable.

Function
REQ-012 Per queue SHALL hold tail, commit_head, inflight_head (PTR_WIDTH), log_size, active; all pointer arithmetic modulo 2^PTR_WIDTH.
REQ-013 req_ready SHALL be (!resp_valid || resp_ready) && op table not full.
REQ-014 Accepted request SHALL produce registered response exactly 1 cycle later, echoing queue and tag.
REQ-015 Queue inactive or enable low: response error=1, empty=0, no pointer/op-table change.
REQ-016 inflight_head == tail: response empty=1, error=0, no allocation.
REQ-017 Otherwise: ptr=inflight_head, op_tag = allocated op-table slot, inflight_head += 1.
REQ-018 Response SHALL hold stable while valid && !ready.
REQ-019 Op table SHALL be circular, allocated and retired in order; commit_ready=1 always.
REQ-020 Commit with op_tag == oldest live slot SHALL retire it and increment that queue's commit_head; any other op_tag (or empty table) SHALL be dropped with no state change.
REQ-021 Doorbell SHALL set tail=ptr only if (ptr - commit_head) mod 2^PTR_WIDTH <= 2^log_size; else ignored.
REQ-022 Same-cycle doorbell and request on same queue: request uses pre-update tail.
REQ-023 Same-cycle commit and request: both applied; a full table freed by that commit still holds req_ready low this cycle.
REQ-024 Back-to-back requests to same queue SHALL see prior cycle's inflight_head update.
REQ-025 cfg write SHALL set log_size/active and reset all three pointers of that queue to 0; concurrent doorbell/request on that queue is overridden by cfg.

Reset
REQ-026 rst_n low at clk edge SHALL clear all pointers, log_size, active, op table; resp_valid=0, req_ready=0 during reset, all resp fields 0.
REQ-027 Reset mid-operation SHALL discard pending response and all in-flight ops without commit.

Configuration
REQ-028 With QPM_STATS_EN defined: outputs stat_dequeue_count, stat_empty_count, stat_error_count (32 bit each, saturating, cleared by reset) increment on each response accepted of that type.
REQ-029 Without QPM_STATS_EN: those ports and counters SHALL not exist.

Verification
REQ-030 Cfg q3 log_size=4 active; doorbell q3 ptr=2; two requests -> ptrs 0,1 op_tags 0,1; third -> empty=1.
REQ-031 Four requests to loaded queue, no commit -> req_ready low; commit op_tag 0 -> req_ready high next cycle, commit_head=1.
REQ-032 commit_head=0xFFFE, doorbell ptr=0x0003 log_size=4 -> accepted; dequeues return 0xFFFE,0xFFFF,0x0000.
REQ-033 Doorbell ptr=17 with log_size=4, commit_head=0 -> ignored, next request empty=1.
REQ-034 enable=0 request q1 tag 0x5A -> error=1, tag=0x5A; resp_ready=0 holds response 5 cycles unchanged.
REQ-035 rst_n low with 2 ops in flight -> resp_valid=0, commit op_tag 0 afterwards dropped.
